ghost_collision: RTL

Per-frame collision detector and life/round manager sitting directly downstream of the ghost movement stage. Consumes the Pac-Man position and the four ghost positions, decides once per frame whether Pac-Man overlaps a ghost, and runs the death/respawn/game-over sequence. Drives freeze and respawn controls back to the movement stages and life count to the HUD renderer.

---
 rtl/ghost_collision_pkg.sv | 31 +++
 rtl/ghost_collision_if.sv | 28 ++
 rtl/ghost_collision_ghost_overlap.sv | 26 ++
 rtl/ghost_collision.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ghost_collision_pkg.sv
// ghost_collision_pkg: shared types and default constants for the collision / life manager.
package ghost_collision_pkg;

   typedef enum logic [1:0] {
      PLAYING = 2'd0,
      DYING   = 2'd1,
      RESPAWN = 2'd2,
      OVER    = 2'd3
   } collision_state_t;

   // Bit position of each ghost in ghost_eaten and in the internal hit vector
   typedef enum logic [1:0] {
      RED    = 2'd0,
      BLUE   = 2'd1,
      YELLOW = 2'd2,
      PINK   = 2'd3
   } ghost_e;

   localparam int NUM_GHOSTS        = 4;
   localparam int POS_W             = 9;
   localparam int LIVES_DEF         = 3;
   localparam int TOL_DEF           = 6;
   localparam int DEATH_FRAMES_DEF  = 120;
   localparam int FRIGHT_FRAMES_DEF = 360;

   // Bits needed to hold values 0..n
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ghost_collision_if.sv
// ghost_collision_if: positions/strobes from the movement stages, control back to them and the HUD.
interface ghost_collision_if;
   import ghost_collision_pkg::*;

   logic             frame_stb;
   logic [POS_W-1:0] x_pac, y_pac;
   logic [POS_W-1:0] x_red, y_red, x_blue, y_blue;
   logic [POS_W-1:0] x_yellow, y_yellow, x_pink, y_pink;
   logic             power_stb;
   logic             freeze;
   logic             respawn;
   logic [2:0]       lives;
   logic             game_over;
   logic             frightened;
   logic [3:0]       ghost_eaten;

   modport master (
      output frame_stb, x_pac, y_pac, x_red, y_red, x_blue, y_blue,
             x_yellow, y_yellow, x_pink, y_pink, power_stb,
      input  freeze, respawn, lives, game_over, frightened, ghost_eaten
   );

   modport slave (
      input  frame_stb, x_pac, y_pac, x_red, y_red, x_blue, y_blue,
             x_yellow, y_yellow, x_pink, y_pink, power_stb,
      output freeze, respawn, lives, game_over, frightened, ghost_eaten
   );
endinterface

// File: rtl/ghost_collision_ghost_overlap.sv
// ghost_overlap: combinational box test between Pac-Man and one ghost.
// Absolute differences are taken larger-minus-smaller so they never wrap.
module ghost_overlap
   import ghost_collision_pkg::*;
#(
   parameter int TOL = TOL_DEF
) (
   input  logic [POS_W-1:0] x_a,
   input  logic [POS_W-1:0] y_a,
   input  logic [POS_W-1:0] x_b,
   input  logic [POS_W-1:0] y_b,
   output logic             hit
);

   localparam logic [POS_W:0] TOL_V = (POS_W+1)'(TOL);

   logic [POS_W-1:0] dx, dy;

   // Unsigned distance per axis, then strict compare against the tolerance
   always_comb begin
      dx  = (x_a >= x_b) ? (x_a - x_b) : (x_b - x_a);
      dy  = (y_a >= y_b) ? (y_a - y_b) : (y_b - y_a);
      hit = ({1'b0, dx} < TOL_V) && ({1'b0, dy} < TOL_V);
   end

endmodule

// File: rtl/ghost_collision.sv
// ghost_collision: per-frame collision detect plus death / respawn / game-over sequencing.
// Optional feature macro: POWER_PELLET_EN (fright counter, ghost_eaten pulses).
// Outputs are decoded from registers only; nothing combinational reaches them from inputs.
module ghost_collision
   import ghost_collision_pkg::*;
#(
   parameter int LIVES         = LIVES_DEF,
   parameter int TOL           = TOL_DEF,
   parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
   parameter int FRIGHT_FRAMES = FRIGHT_FRAMES_DEF
) (
   input logic              vga_pix_clk,
   input logic              rst_n,
   ghost_collision_if.slave gc
);

   localparam int DC_W = cnt_w(DEATH_FRAMES);
   localparam int FC_W = cnt_w(FRIGHT_FRAMES);

   collision_state_t                     state_q, state_d;
   logic [2:0]                           lives_q, lives_d;
   logic [DC_W-1:0]                      death_q, death_d;
   logic [NUM_GHOSTS-1:0][POS_W-1:0]     x_g, y_g;
   logic [NUM_GHOSTS-1:0]                hit;
   logic                                 any_hit;
   logic                                 fright_now;
   logic [NUM_GHOSTS-1:0]                eaten_d;

   assign x_g[RED]    = gc.x_red;     assign y_g[RED]    = gc.y_red;
   assign x_g[BLUE]   = gc.x_blue;    assign y_g[BLUE]   = gc.y_blue;
   assign x_g[YELLOW] = gc.x_yellow;  assign y_g[YELLOW] = gc.y_yellow;
   assign x_g[PINK]   = gc.x_pink;    assign y_g[PINK]   = gc.y_pink;

   for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ovl
      ghost_overlap #(.TOL(TOL)) u_ovl (
         .x_a (gc.x_pac),
         .y_a (gc.y_pac),
         .x_b (x_g[g]),
         .y_b (y_g[g]),
         .hit (hit[g])
      );
   end

   assign any_hit = |hit;

`ifdef POWER_PELLET_EN
   logic [FC_W-1:0]       fright_q, fright_d;
   logic [NUM_GHOSTS-1:0] eaten_q;

   // Hits are judged against the registered count, so a same-cycle power_stb does not rescue Pac-Man
   assign fright_now = (fright_q != '0);

   // Fright window: reload on pellet while playing, clear on respawn, count down per frame
   always_comb begin
      fright_d = fright_q;
      if (state_q == RESPAWN)
         fright_d = '0;
      else if (state_q == PLAYING && gc.power_stb)
         fright_d = FC_W'(FRIGHT_FRAMES);
      else if (gc.frame_stb && fright_now)
         fright_d = fright_q - 1'b1;
   end

   // Fright counter and one-cycle eaten pulses
   always_ff @(posedge vga_pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         fright_q <= '0;
         eaten_q  <= '0;
      end else begin
         fright_q <= fright_d;
         eaten_q  <= eaten_d;
      end
   end

   assign gc.frightened  = fright_now;
   assign gc.ghost_eaten = eaten_q;
`else
   logic unused_power_stb;

   assign unused_power_stb = gc.power_stb;
   assign fright_now       = 1'b0;
   assign gc.frightened    = 1'b0;
   assign gc.ghost_eaten   = '0;
`endif

   // Next-state: hit handling in PLAYING, death countdown in DYING, one-cycle RESPAWN
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      death_d = death_q;
      eaten_d = '0;
      unique case (state_q)
         PLAYING: begin
            if (gc.frame_stb && any_hit) begin
               if (fright_now) begin
                  eaten_d = hit;
               end else begin
                  // Any number of simultaneous hits costs a single life
                  lives_d = lives_q - 3'd1;
                  death_d = DC_W'(DEATH_FRAMES - 1);
                  state_d = DYING;
               end
            end
         end
         DYING: begin
            if (gc.frame_stb) begin
               if (death_q == '0)
                  state_d = (lives_q == 3'd0) ? OVER : RESPAWN;
               else
                  death_d = death_q - 1'b1;
            end
         end
         RESPAWN: state_d = PLAYING;
         OVER:    state_d = OVER;
         default: state_d = PLAYING;
      endcase
   end

   // State, lives and death counter registers
   always_ff @(posedge vga_pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PLAYING;
         lives_q <= 3'(LIVES);
         death_q <= '0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         death_q <= death_d;
      end
   end

   assign gc.freeze    = (state_q != PLAYING);
   assign gc.respawn   = (state_q == RESPAWN);
   assign gc.game_over = (state_q == OVER);
   assign gc.lives     = lives_q;

endmodule
